// File: rtl/inst_rom_resp.sv
// Instruction-memory responder for the fetch stage.
// Takes the PC register's address/chip-enable, reads a word-addressed on-chip
// instruction array and returns the word one cycle later, tagged with its PC.
// The array can be loaded through a write port while fetching is disabled.
module inst_rom_resp #(
   parameter int          AW         = 32,
   parameter int          DW         = 32,
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_ce,
   input  logic [AW-1:0]         i_pc,
   input  logic [5:0]            i_stall,
   input  logic                  i_ld_en,
   input  logic [DEPTH_LOG2-1:0] i_ld_addr,
   input  logic [DW-1:0]         i_ld_data,
   output logic [DW-1:0]         o_inst,
   output logic                  o_inst_vld,
   output logic [AW-1:0]         o_pc_out,
   output logic                  o_adel,
   output logic                  o_ld_err,
   output logic [31:0]           o_fetch_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Instruction array (not reset) and its registered read port.
   logic [DW-1:0]         mem [0:DEPTH-1];
   logic [DW-1:0]         rd_data_reg;

   // Control/output registers.
   state_t                state_reg;
   logic                  inst_sel_reg;    // 1: o_inst shows the array word
   logic                  inst_vld_reg;
   logic [AW-1:0]         pc_out_reg;
   logic                  adel_reg;
   logic                  ld_err_reg;
   logic [31:0]           fetch_cnt_reg;

   // Decoded fetch-side signals.
   logic                  stall_ifid;
   logic                  fetch_go;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  addr_err;
   logic [DEPTH_LOG2-1:0] word_idx;
   logic                  load_ok;

   // Only the IF/ID bit of the stall vector matters here.
   logic                  stall_unused;
   assign stall_unused = &{1'b0, i_stall[5:2], i_stall[0]};

   assign stall_ifid = i_stall[1];
   assign fetch_go   = i_ce & ~stall_ifid;
   assign misaligned = |i_pc[1:0];
   assign word_idx   = i_pc[DEPTH_LOG2+1:2];
   assign load_ok    = i_ld_en & ~i_ce;

   // Any address bit above the array's byte span marks the fetch out of range;
   // when the array spans the whole address space nothing can be out of range.
   generate
      if (AW > DEPTH_LOG2 + 2) begin : g_range_chk
         assign out_of_range = |i_pc[AW-1:DEPTH_LOG2+2];
      end else begin : g_no_range_chk
         assign out_of_range = 1'b0;
      end
   endgenerate

   assign addr_err = misaligned | out_of_range;

   // Array write (program load) and registered read (fetch). Loads and
   // fetches are mutually exclusive through i_ce, so no same-index collision.
   // The read register only advances on a fetch so a stall holds the word.
   always_ff @(posedge i_clk) begin
      if (load_ok) begin
         mem[i_ld_addr] <= i_ld_data;
      end
      if (fetch_go) begin
         rd_data_reg <= mem[word_idx];
      end
   end

   // Fetch FSM: state transitions and all registered status outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg     <= ST_OFF;
         inst_sel_reg  <= 1'b0;
         inst_vld_reg  <= 1'b0;
         pc_out_reg    <= '0;
         adel_reg      <= 1'b0;
         ld_err_reg    <= 1'b0;
         fetch_cnt_reg <= '0;
      end else begin
         // A load while fetching is dropped and flagged for one cycle.
         ld_err_reg <= i_ld_en & i_ce;

         if (!i_ce) begin
            // Disabling fetch wins over stall: blank the output, keep PC/count.
            state_reg    <= ST_OFF;
            inst_sel_reg <= 1'b0;
            inst_vld_reg <= 1'b0;
            adel_reg     <= 1'b0;
         end else begin
            case (state_reg)
               ST_OFF:  state_reg <= stall_ifid ? ST_HOLD : ST_RUN;
               ST_RUN:  state_reg <= stall_ifid ? ST_HOLD : ST_RUN;
               ST_HOLD: state_reg <= stall_ifid ? ST_HOLD : ST_RUN;
               default: state_reg <= ST_OFF;
            endcase

            if (!stall_ifid) begin
               inst_sel_reg <= ~addr_err;
               inst_vld_reg <= 1'b1;
               pc_out_reg   <= i_pc;
               adel_reg     <= addr_err;
               if (fetch_cnt_reg != 32'hFFFF_FFFF) begin
                  fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
               end
            end
         end
      end
   end

   assign o_inst      = inst_sel_reg ? rd_data_reg : NOP_WORD[DW-1:0];
   assign o_inst_vld  = inst_vld_reg;
   assign o_pc_out    = pc_out_reg;
   assign o_adel      = adel_reg;
   assign o_ld_err    = ld_err_reg;
   assign o_fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed testbench for inst_rom_resp: preload, streaming, stall, address
// errors, illegal load, mid-run reset and chip-enable drop.
module tb_inst_rom_resp;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int DL = 10;

   logic          clk;
   logic          rst_n;
   logic          ce;
   logic [AW-1:0] pc;
   logic [5:0]    stall;
   logic          ld_en;
   logic [DL-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic [DW-1:0] inst;
   logic          inst_vld;
   logic [AW-1:0] pc_out;
   logic          adel;
   logic          ld_err;
   logic [31:0]   fetch_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] prog [0:3];

   inst_rom_resp #(.AW(AW), .DW(DW), .DEPTH_LOG2(DL), .NOP_WORD(32'h0)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_ce        (ce),
      .i_pc        (pc),
      .i_stall     (stall),
      .i_ld_en     (ld_en),
      .i_ld_addr   (ld_addr),
      .i_ld_data   (ld_data),
      .o_inst      (inst),
      .o_inst_vld  (inst_vld),
      .o_pc_out    (pc_out),
      .o_adel      (adel),
      .o_ld_err    (ld_err),
      .o_fetch_cnt (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full output check after a transaction, one line per transaction.
   task automatic chk_out(input string tag, input logic [31:0] e_inst, input logic e_vld,
                          input logic [31:0] e_pc, input logic e_adel, input logic [31:0] e_cnt);
      $display("%s: inst=%h vld=%b pc=%h adel=%b cnt=%0d ld_err=%b",
               tag, inst, inst_vld, pc_out, adel, fetch_cnt, ld_err);
      chk({tag, ".inst"}, 64'(inst), 64'(e_inst));
      chk({tag, ".vld"},  64'(inst_vld), 64'(e_vld));
      chk({tag, ".pc"},   64'(pc_out), 64'(e_pc));
      chk({tag, ".adel"}, 64'(adel), 64'(e_adel));
      chk({tag, ".cnt"},  64'(fetch_cnt), 64'(e_cnt));
   endtask

   initial begin
      prog[0] = 32'h3401_1100;
      prog[1] = 32'h3402_0020;
      prog[2] = 32'h0041_1825;
      prog[3] = 32'h0000_0000;

      rst_n = 1'b0; ce = 1'b0; pc = '0; stall = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      #2;

      // Reset state
      step();
      chk_out("reset", 32'h0, 1'b0, 32'h0, 1'b0, 32'd0);
      chk("reset.ld_err", 64'(ld_err), 64'd0);
      rst_n = 1'b1;

      // Program preload with fetch disabled
      for (int i = 0; i < 4; i++) begin
         ld_en = 1'b1; ld_addr = DL'(i); ld_data = prog[i];
         step();
         chk("load.ld_err", 64'(ld_err), 64'd0);
      end
      ld_en = 1'b0;
      chk_out("off_after_load", 32'h0, 1'b0, 32'h0, 1'b0, 32'd0);

      // Streaming fetches
      ce = 1'b1; pc = 32'h0;
      step(); chk_out("fetch_pc0", prog[0], 1'b1, 32'h0, 1'b0, 32'd1);
      pc = 32'h4;
      step(); chk_out("fetch_pc4", prog[1], 1'b1, 32'h4, 1'b0, 32'd2);

      // Stall while pc=8 is presented: output holds pc=4 word
      pc = 32'h8; stall = 6'b000011;
      for (int i = 0; i < 3; i++) begin
         step(); chk_out("stall_hold", prog[1], 1'b1, 32'h4, 1'b0, 32'd2);
      end
      stall = 6'b0;
      step(); chk_out("fetch_pc8", prog[2], 1'b1, 32'h8, 1'b0, 32'd3);
      pc = 32'hC;
      step(); chk_out("fetch_pcC", prog[3], 1'b1, 32'hC, 1'b0, 32'd4);

      // Address errors: misaligned then out of range
      pc = 32'h0000_0006;
      step(); chk_out("adel_misalign", 32'h0, 1'b1, 32'h6, 1'b1, 32'd5);
      pc = 32'h0000_1000;
      step(); chk_out("adel_range", 32'h0, 1'b1, 32'h1000, 1'b1, 32'd6);
      pc = 32'h0;
      step(); chk_out("after_adel", prog[0], 1'b1, 32'h0, 1'b0, 32'd7);

      // Illegal load while fetching
      ld_en = 1'b1; ld_addr = '0; ld_data = 32'hDEAD_BEEF; pc = 32'h4;
      step();
      chk_out("ill_load", prog[1], 1'b1, 32'h4, 1'b0, 32'd8);
      chk("ill_load.ld_err", 64'(ld_err), 64'd1);
      ld_en = 1'b0; pc = 32'h0;
      step();
      chk_out("ill_load_refetch", prog[0], 1'b1, 32'h0, 1'b0, 32'd9);
      chk("ill_load.ld_err_end", 64'(ld_err), 64'd0);

      // Reset mid-stream; array survives
      pc = 32'h8; rst_n = 1'b0;
      step(); chk_out("mid_reset", 32'h0, 1'b0, 32'h0, 1'b0, 32'd0);
      rst_n = 1'b1; pc = 32'h0;
      step(); chk_out("post_reset_pc0", prog[0], 1'b1, 32'h0, 1'b0, 32'd1);
      pc = 32'h8;
      step(); chk_out("post_reset_pc8", prog[2], 1'b1, 32'h8, 1'b0, 32'd2);

      // ce drop during stall: OFF wins
      stall = 6'b000010; pc = 32'hC;
      step(); chk_out("pre_drop_hold", prog[2], 1'b1, 32'h8, 1'b0, 32'd2);
      ce = 1'b0;
      step(); chk_out("ce_drop", 32'h0, 1'b0, 32'h8, 1'b0, 32'd2);

      // OFF -> HOLD keeps output blank, then release fetches
      ce = 1'b1;
      step(); chk_out("off_to_hold", 32'h0, 1'b0, 32'h8, 1'b0, 32'd2);
      stall = 6'b0; pc = 32'h4;
      step(); chk_out("hold_to_run", prog[1], 1'b1, 32'h4, 1'b0, 32'd3);

      // Adel cleared when fetch is disabled
      pc = 32'h2;
      step(); chk_out("adel_again", 32'h0, 1'b1, 32'h2, 1'b1, 32'd4);
      ce = 1'b0;
      step(); chk_out("adel_off", 32'h0, 1'b0, 32'h2, 1'b0, 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_rom_resp.md
Name: inst_rom_resp

Overview:
- Instruction-memory responder at the far end of the fetch interface driven by the PC register.
- Accepts the fetch address and chip-enable from the PC register, looks up a word-addressed on-chip instruction array, and returns the instruction one cycle later, tagged with its PC.
- Holds its output while the IF/ID stage is stalled.
- Provides a program-load write port, usable only while the PC register's chip-enable is low.

Parameters:
- AW, 32 (`N_INST_ADDR): fetch address width.
- DW, 32: instruction width.
- DEPTH_LOG2, 10: log2 of array depth in words (default 1024 words).
- NOP_WORD, 32'h0000_0000: instruction returned on error or when disabled.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_ce  input  1  chip-enable from PC register; 1 = fetch active.
- i_pc  input  AW  byte fetch address.
- i_stall  input  6  pipeline stall vector; bit 1 (IF/ID) is used.
- i_ld_en  input  1  program-load write strobe.
- i_ld_addr  input  DEPTH_LOG2  word index for load write.
- i_ld_data  input  DW  load write data.
- o_inst  output  DW  fetched instruction.
- o_inst_vld  output  1  o_inst holds a real fetch result.
- o_pc_out  output  AW  PC that o_inst belongs to.
- o_adel  output  1  address error for the current o_inst (misaligned or out of range).
- o_ld_err  output  1  one-cycle pulse: load attempted while i_ce=1.
- o_fetch_cnt  output  32  count of delivered fetches, saturating.

Behaviour:
- Reset: synchronous; i_rst_n=0 sampled at an edge has priority over everything and places the block in state OFF.
  - Reset values: o_inst=NOP_WORD, o_inst_vld=0, o_pc_out=0, o_adel=0, o_ld_err=0, o_fetch_cnt=0.
  - Array contents are not reset.
  - Reset mid-fetch discards the in-flight fetch; no output from it ever appears.
- FSM states: OFF, RUN, HOLD.
  - OFF -> RUN when i_ce=1 and i_stall[1]=0.
  - OFF -> HOLD when i_ce=1 and i_stall[1]=1.
  - RUN -> HOLD when i_stall[1]=1.
  - HOLD -> RUN when i_stall[1]=0.
  - Any state -> OFF when i_ce=0. i_ce=0 overrides stall.
- Fetch:
  - Fetch condition: i_ce=1, i_stall[1]=0 and not in reset.
  - When the fetch condition holds at edge N, the registered outputs update and are visible after edge N: o_pc_out=i_pc, o_inst_vld=1, o_inst from the array or NOP_WORD.
  - Latency is exactly 1 cycle; one fetch can be accepted per cycle.
- Address check:
  - Misaligned: i_pc[1:0]!=0.
  - Out of range: i_pc[AW-1:DEPTH_LOG2+2]!=0.
  - Either condition gives o_adel=1, o_inst=NOP_WORD, o_inst_vld=1.
  - Otherwise the word index is i_pc[DEPTH_LOG2+1:2] and o_adel=0.
- Stall (i_stall[1]=1 with i_ce=1): o_inst, o_pc_out, o_adel, o_inst_vld and o_fetch_cnt all hold their values.
- OFF state outputs: o_inst_vld=0, o_inst=NOP_WORD, o_adel=0. o_pc_out and o_fetch_cnt hold.
- Load port:
  - i_ld_en=1 with i_ce=0 writes i_ld_data to array[i_ld_addr] at the edge.
  - i_ld_en=1 with i_ce=1: the write is dropped and o_ld_err=1 for exactly the next cycle. It is otherwise 0.
- Read/write collision to the same index in the same cycle cannot occur, because loads and fetches are mutually exclusive via i_ce.
- o_fetch_cnt:
  - Increments by 1 on each fetch condition, including address-error fetches.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset.

Test Plan:
- Program preload:
  - Stimulus: i_ce=0; load array[0..3]=32'h3401_1100, 32'h3402_0020, 32'h0041_1825, 32'h0000_0000. Then raise i_ce and step i_pc 0,4,8,C.
  - Required response: one cycle later, o_inst streams those four words in order with o_pc_out=0,4,8,C, o_inst_vld=1, o_fetch_cnt reaching 4.
- Stall hold:
  - Stimulus: during streaming, i_stall=6'b000011 for 3 cycles while the fetch at i_pc=8 is being presented.
  - Required response: o_inst holds 32'h3402_0020, o_pc_out holds 4, and the count holds for those 3 cycles. On release, the next output is pc=8 / 32'h0041_1825.
- Address errors:
  - Stimulus: i_pc=32'h0000_0006, then i_pc=32'h0000_1000 (DEPTH_LOG2=10).
  - Required response: each returns o_adel=1, o_inst=0, o_inst_vld=1, and o_pc_out equal to the faulting PC.
- Illegal load:
  - Stimulus: i_ld_en=1 while i_ce=1 with i_ld_addr=0 and i_ld_data=32'hDEAD_BEEF.
  - Required response: o_ld_err pulses for 1 cycle; a later fetch of pc=0 still returns 32'h3401_1100.
- Reset mid-operation:
  - Stimulus: i_rst_n=0 for one edge during streaming.
  - Required response: after that edge, o_inst_vld=0, o_fetch_cnt=0, o_pc_out=0; the array is preserved, so re-fetching pc=0 returns 32'h3401_1100.
- ce drop:
  - Stimulus: i_ce goes 0 while i_stall[1]=1.
  - Required response: the next cycle shows o_inst_vld=0 and o_inst=0 (state OFF). The stall does not keep the old output.
